// File: rtl/aes_dec_pkg.sv
// Shared types and helpers for the AES-256 decryption datapath.
package aes_dec_pkg;

  localparam int unsigned AES_LAST_ROUND = 14;

  typedef logic [31:0]  aes_col_t;
  typedef logic [127:0] aes_state_t;

  // InvMixColumns is skipped on the first (last_round) and final (0) rounds.
  function automatic logic inv_mix_en(input logic [3:0]  round,
                                      input int unsigned last_round = AES_LAST_ROUND);
    return (round != 4'd0) && (32'(round) != last_round);
  endfunction

  // Column 0 occupies the most significant word.
  function automatic aes_col_t get_col(input aes_state_t state, input logic [1:0] idx);
    aes_col_t col;
    col = '0;
    unique case (idx)
      2'd0: col = state[127:96];
      2'd1: col = state[95:64];
      2'd2: col = state[63:32];
      2'd3: col = state[31:0];
      default: col = '0;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/aes_inv_addkey_colser.sv
// Column-serial AddRoundKey: XORs a 128-bit state with its round key at load and
// streams the result as four 32-bit columns tagged for the downstream InvMixColumns.
module aes_inv_addkey_colser
  import aes_dec_pkg::*;
#(
  parameter int unsigned LAST_ROUND = AES_LAST_ROUND
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  input  logic [3:0]   in_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_col,
  output logic [1:0]   out_idx,
  output logic         out_last,
  output logic         out_mix,
  output logic         err
);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e     state_q, state_d;
  aes_state_t data_q, data_d;
  logic [1:0] idx_q, idx_d;
  logic       mix_q, mix_d;
  logic       err_q, err_d;

  logic accept, legal, last_col;

  assign last_col = (idx_q == 2'd3);
  assign legal    = (32'(in_round) <= LAST_ROUND);
  // A new block may enter on the same cycle the final column is taken.
  assign in_ready = (state_q == StIdle) || ((state_q == StStream) && last_col && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    mix_d   = mix_q;
    err_d   = accept && !legal;

    unique case (state_q)
      StIdle: begin
        if (accept && legal) begin
          data_d  = in_state ^ in_key;
          mix_d   = inv_mix_en(in_round, LAST_ROUND);
          idx_d   = 2'd0;
          state_d = StStream;
        end
      end
      StStream: begin
        if (out_ready) begin
          if (!last_col) begin
            idx_d = idx_q + 2'd1;
          end else if (accept && legal) begin
            data_d = in_state ^ in_key;
            mix_d  = inv_mix_en(in_round, LAST_ROUND);
            idx_d  = 2'd0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      idx_q   <= 2'd0;
      mix_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      mix_q   <= mix_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == StStream);
  assign out_col   = out_valid ? get_col(data_q, idx_q) : '0;
  assign out_idx   = out_valid ? idx_q : 2'd0;
  assign out_last  = out_valid && last_col;
  assign out_mix   = out_valid && mix_q;
  assign err       = err_q;

endmodule

// File: tb/tb_aes_inv_addkey_colser.sv
// Randomised and directed bench for aes_inv_addkey_colser against a column-queue model.
module tb_aes_inv_addkey_colser;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic [127:0] in_key = '0;
  logic [3:0]   in_round = 4'd0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_col;
  logic [1:0]   out_idx;
  logic         out_last;
  logic         out_mix;
  logic         err;

  aes_inv_addkey_colser dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_state (in_state),
    .in_key   (in_key),
    .in_round (in_round),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_col  (out_col),
    .out_idx  (out_idx),
    .out_last (out_last),
    .out_mix  (out_mix),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] col;
    logic [1:0]  idx;
    logic        last;
    logic        mix;
  } col_t;

  col_t q[$];
  logic err_exp = 1'b0;
  int   ncmp = 0;
  int   nfail = 0;
  bit   rand_ready = 1'b0;

  localparam logic [127:0] TpState = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] TpKey   = 128'h00010203_04050607_08090a0b_0c0d0e0f;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected stream of a legal block: four XORed words, MSB word first.
  task automatic push_block(input logic [127:0] st, input logic [127:0] ky, input int rnd);
    col_t c;
    logic [127:0] x;
    x = st ^ ky;
    for (int k = 0; k < 4; k++) begin
      c.col  = x[127 - 32*k -: 32];
      c.idx  = 2'(k);
      c.last = (k == 3);
      c.mix  = (rnd >= 1) && (rnd <= 13);
      q.push_back(c);
    end
  endtask

  // One clock cycle: entered and left at negedge+1 with inputs for this cycle set.
  task automatic cyc(output bit acc);
    logic exp_ready;
    bit   ohs;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    #1;
    exp_ready = (q.size() == 0) || (q.size() == 1 && out_ready);
    chk("in_ready", 128'(in_ready), 128'(exp_ready));
    chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
    chk("err", 128'(err), 128'(err_exp));
    if (q.size() != 0) begin
      chk("out_col", 128'(out_col), 128'(q[0].col));
      chk("out_idx", 128'(out_idx), 128'(q[0].idx));
      chk("out_last", 128'(out_last), 128'(q[0].last));
      chk("out_mix", 128'(out_mix), 128'(q[0].mix));
    end
    ohs = (q.size() != 0) && out_ready;
    acc = in_valid && exp_ready;
    if (ohs) void'(q.pop_front());
    err_exp = acc && (in_round > 4'd14);
    if (acc && in_round <= 4'd14) push_block(in_state, in_key, int'(in_round));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [127:0] st, input logic [127:0] ky, input logic [3:0] rnd);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_state = st;
    in_key   = ky;
    in_round = rnd;
    for (int i = 0; i < 40 && !acc; i++) cyc(acc);
    if (!acc) begin
      nfail++;
      $error("FAIL send_timeout: observed no accept expected accept");
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cyc(acc);
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 60 && q.size() != 0; i++) cyc(acc);
    if (q.size() != 0) begin
      nfail++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", q.size());
    end
    idle(1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_col", 128'(out_col), 128'(0));
    chk("rst_out_idx", 128'(out_idx), 128'(0));
    chk("rst_out_last", 128'(out_last), 128'(0));
    chk("rst_out_mix", 128'(out_mix), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
  endtask

  initial begin : main
    logic [31:0] tp_cols [4];
    bit acc;
    tp_cols[0] = 32'h00102030;
    tp_cols[1] = 32'h40506070;
    tp_cols[2] = 32'h8090a0b0;
    tp_cols[3] = 32'hc0d0e0f0;

    // Reset
    @(negedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Round 14 directed block, explicit column values
    send(TpState, TpKey, 4'd14);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("tp_col", 128'(out_col), 128'(tp_cols[k]));
      chk("tp_mix14", 128'(out_mix), 128'(0));
      cyc(acc);
    end
    idle(1);

    // Rounds 7 and 0
    send(TpState, TpKey, 4'd7);
    #1;
    chk("tp_mix7", 128'(out_mix), 128'(1));
    drain();
    send(TpState, TpKey, 4'd0);
    drain();

    // Backpressure while column 1 pending
    send(TpState, TpKey, 4'd5);
    cyc(acc);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_col", 128'(out_col), 128'(32'h40506070));
      chk("bp_idx", 128'(out_idx), 128'(1));
      cyc(acc);
    end
    out_ready = 1'b1;
    cyc(acc);
    #1;
    chk("bp_next_idx", 128'(out_idx), 128'(2));
    drain();

    // Back-to-back blocks
    send(TpState, TpKey, 4'd3);
    send(~TpState, TpKey, 4'd12);
    drain();

    // Illegal round, alone and at the last-column handshake
    send(TpState, TpKey, 4'd15);
    idle(2);
    send(TpState, TpKey, 4'd9);
    send(TpState, TpKey, 4'd15);
    idle(2);
    send(TpState, ~TpKey, 4'd1);
    drain();

    // Reset mid-block after column 1 handshake
    send(TpState, TpKey, 4'd4);
    cyc(acc);
    cyc(acc);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    q.delete();
    err_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    send(TpState, TpKey, 4'd2);
    drain();

    // Random blocks, random backpressure and gaps
    rand_ready = 1'b1;
    for (int b = 0; b < 40; b++) begin
      send({$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom},
           4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
